bg_theme_sequencer: RTL
=======================

Name: bg_theme_sequencer

Overview:
- Frame-synchronous controller that supplies the background generator with its base fill colour and its bracket-line colour.
- Sequences theme changes on level-up (fade-out, theme swap, fade-in) and short colour-inverted "hit" flashes.
- Sits between game logic and the background draw block; all colour changes happen on frame boundaries so no frame tears.
- Colours are 8-bit RRRGGGBB.

Parameters:
- FRAMES_PER_STEP, 4, frames each fade level is held (1..15).
- FLASH_FRAMES, 6, frames a flash lasts (1..15).
- NUM_THEMES, 4, number of entries in the theme ROM (max 4).

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous reset, active-high (port name kept per codebase; the polarity is fixed high).
- startOfFrame  in  1  one-cycle pulse per frame.
- levelUpReq  in  1  request a theme change; any cycle.
- flashReq  in  1  request a hit flash; any cycle.
- baseRGB  out  8  background fill colour, registered.
- lineRGB  out  8  bracket/border line colour, registered.
- themeIdx  out  2  current theme index.
- busy  out  1  high when state is not SHOW.
- transitionDone  out  1  one-cycle pulse on FADE_IN -> SHOW.

Behaviour:
- Reset (synchronous, resetN=1), also mid-fade or mid-flash:
  - state=SHOW, themeIdx=0, k=7, frameCnt=0, pending=0.
  - baseRGB=0x58, lineRGB=0xFF, busy=0, transitionDone=0.
- Theme ROM (base, line): T0 0x58/0xFF, T1 0x03/0xFC, T2 0xE0/0x1F, T3 0x49/0xB6.
- Fade level k (0..7); 7 is full colour. For each target colour:
  - R' = sat0(R-(7-k)), G' = sat0(G-(7-k)), B' = sat0(B-((7-k)>>1)).
  - Unsigned; negative results clamp to 0.
- States:
  - SHOW:
    - Outputs are the ROM colours at k=7.
    - levelUpReq sets pending.
    - flashReq (with levelUpReq low) -> FLASH next cycle, frameCnt=0.
    - startOfFrame with pending=1 -> FADE_OUT, k=7, frameCnt=0, pending cleared.
    - levelUpReq and flashReq in the same cycle: levelUp wins, flash is dropped.
  - FADE_OUT, on each startOfFrame:
    - if frameCnt==FRAMES_PER_STEP-1: frameCnt=0; if k==0 -> SWAP, else k--.
    - otherwise frameCnt++.
  - SWAP: lasts one cycle. themeIdx = (themeIdx+1) mod NUM_THEMES. -> FADE_IN with k=0, frameCnt=0.
  - FADE_IN: same counting rule as FADE_OUT, with k++. At k==7 when the step completes -> SHOW and transitionDone pulses.
  - FLASH:
    - baseRGB = ~ROM base; lineRGB unchanged.
    - Each startOfFrame increments frameCnt; reaching FLASH_FRAMES -> SHOW.
    - flashReq during FLASH restarts frameCnt=0.
    - levelUpReq during FLASH sets pending.
- Requests during FADE_OUT, SWAP or FADE_IN are ignored; they are not latched.
- Fade timing with defaults: 32 frames out, 1 cycle swap, 32 frames in.
- Latency: outputs are registered and reflect state/k/themeIdx one clock after they change. busy follows state with the same one-cycle latency.
- themeIdx wraps from NUM_THEMES-1 to 0.

Decomposition:
- Package bg_theme_pkg holds:
  - state enum (SHOW, FADE_OUT, SWAP, FADE_IN, FLASH);
  - theme ROM constant array;
  - function fade_rgb(rgb, k).
- One sub-module, bg_frame_step_counter: frameCnt plus the step-complete strobe, with clear/enable; shared by the fade and flash paths.

Test Plan:
- Reset, then idle frames -> baseRGB=0x58, lineRGB=0xFF, busy=0, themeIdx=0.
- levelUpReq pulse, then frames:
  - baseRGB reaches 0x10 and lineRGB 0xB6 (k=5) after 8 frames;
  - both reach 0x00 at k=0;
  - themeIdx becomes 1;
  - baseRGB returns to 0x03 after 64 frames total;
  - transitionDone pulses exactly once.
- flashReq in SHOW -> next cycle baseRGB=0xA7, lineRGB=0xFF; SHOW again after 6 frames. A retrigger at frame 3 extends the flash to 9 frames.
- levelUpReq and flashReq in the same cycle -> no flash; fade starts at the next startOfFrame.
- levelUpReq during FADE_IN ignored -> themeIdx advances only once. Four level-ups wrap themeIdx 3->0 with baseRGB 0x58.
- Reset asserted mid-FADE_OUT (k=3) -> the next cycle shows reset values and no transitionDone pulse.

Source files
------------

// File: rtl/bg_theme_pkg.sv
// Shared types, theme colour table and the fade helper for the background
// theme sequencer. Colours are RRRGGGBB.
package bg_theme_pkg;

  typedef enum logic [2:0] {
    SHOW     = 3'd0,
    FADE_OUT = 3'd1,
    SWAP     = 3'd2,
    FADE_IN  = 3'd3,
    FLASH    = 3'd4
  } state_t;

  localparam logic [2:0] K_FULL = 3'd7;

  // Theme table, index 0..3: base fill colour and bracket-line colour.
  localparam logic [7:0] THEME_BASE [4] = '{8'h58, 8'h03, 8'hE0, 8'h49};
  localparam logic [7:0] THEME_LINE [4] = '{8'hFF, 8'hFC, 8'h1F, 8'hB6};

  // Dim a colour towards black: level k=7 is full colour, k=0 darkest.
  // Red and green drop by (7-k), blue (2 bits) by half that; clamp at 0.
  function automatic logic [7:0] fade_rgb(input logic [7:0] rgb, input logic [2:0] k);
    logic [2:0] d;
    logic [3:0] r;
    logic [3:0] g;
    logic [2:0] b;
    d = K_FULL - k;
    r = {1'b0, rgb[7:5]} - {1'b0, d};
    g = {1'b0, rgb[4:2]} - {1'b0, d};
    b = {1'b0, rgb[1:0]} - {1'b0, d[2:1]};
    return {(r[3] ? 3'd0 : r[2:0]),
            (g[3] ? 3'd0 : g[2:0]),
            (b[2] ? 2'd0 : b[1:0])};
  endfunction

endpackage

// File: rtl/bg_theme_sequencer_counter.sv
// Frame counter shared by the fade and flash paths. Counts enabled frames
// up to 'limit', then wraps to 0 and raises step_done for that frame.
module bg_frame_step_counter (
  input  logic       clk,
  input  logic       resetN,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] limit,
  output logic       step_done
);

  logic [3:0] frame_cnt;

  // clear has priority so a restart never also reports a completed step
  assign step_done = en && !clr && (frame_cnt == limit);

  // frame counter register with synchronous clear/wrap
  always_ff @(posedge clk) begin
    if (resetN) begin
      frame_cnt <= 4'd0;
    end else if (clr) begin
      frame_cnt <= 4'd0;
    end else if (en) begin
      frame_cnt <= (frame_cnt == limit) ? 4'd0 : frame_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/bg_theme_sequencer.sv
// Background theme sequencer: supplies base/line colours to the background
// draw block, sequencing level-up theme fades and hit flashes on frame
// boundaries.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   SHOW     | steady theme colours at full level, accepts requests
//   FADE_OUT | dimming k 7->0, one level per FRAMES_PER_STEP frames
//   SWAP     | single cycle, advance theme index
//   FADE_IN  | brightening k 0->7, returns to SHOW with transitionDone
//   FLASH    | base colour inverted for FLASH_FRAMES frames
module bg_theme_sequencer
  import bg_theme_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 4,
  parameter int FLASH_FRAMES    = 6,
  parameter int NUM_THEMES      = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       levelUpReq,
  input  logic       flashReq,
  output logic [7:0] baseRGB,
  output logic [7:0] lineRGB,
  output logic [1:0] themeIdx,
  output logic       busy,
  output logic       transitionDone
);

  localparam logic [3:0] FADE_LIMIT  = 4'(FRAMES_PER_STEP - 1);
  localparam logic [3:0] FLASH_LIMIT = 4'(FLASH_FRAMES - 1);
  localparam logic [1:0] THEME_LAST  = 2'(NUM_THEMES - 1);

  state_t     state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [1:0] theme_q, theme_d;
  logic       pending_q, pending_d;
  logic       done_q, done_d;
  logic       cnt_clr, cnt_en, step_done;
  logic [3:0] cnt_limit;

  assign cnt_en    = startOfFrame &&
                     (state_q inside {FADE_OUT, FADE_IN, FLASH});
  assign cnt_limit = (state_q == FLASH) ? FLASH_LIMIT : FADE_LIMIT;
  assign themeIdx  = theme_q;

  bg_frame_step_counter u_step_cnt (
    .clk       (clk),
    .resetN    (resetN),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .limit     (cnt_limit),
    .step_done (step_done)
  );

  // sequencer state registers
  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q   <= SHOW;
      k_q       <= K_FULL;
      theme_q   <= 2'd0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      theme_q   <= theme_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  // next-state logic; a level-up always beats a same-cycle flash request
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    theme_d   = theme_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    cnt_clr   = 1'b0;
    unique case (state_q)
      SHOW: begin
        if (startOfFrame && pending_q) begin
          state_d   = FADE_OUT;
          k_d       = K_FULL;
          pending_d = 1'b0;
          cnt_clr   = 1'b1;
        end else if (levelUpReq) begin
          pending_d = 1'b1;
        end else if (flashReq) begin
          state_d = FLASH;
          cnt_clr = 1'b1;
        end
      end
      FADE_OUT: begin
        if (step_done) begin
          if (k_q == 3'd0) state_d = SWAP;
          else             k_d     = k_q - 3'd1;
        end
      end
      SWAP: begin
        theme_d = (theme_q == THEME_LAST) ? 2'd0 : theme_q + 2'd1;
        state_d = FADE_IN;
        k_d     = 3'd0;
        cnt_clr = 1'b1;
      end
      FADE_IN: begin
        if (step_done) begin
          if (k_q == K_FULL) begin
            state_d = SHOW;
            done_d  = 1'b1;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      FLASH: begin
        if (levelUpReq) pending_d = 1'b1;
        if (flashReq)       cnt_clr = 1'b1;
        else if (step_done) state_d = SHOW;
      end
      default: state_d = SHOW;
    endcase
  end

  // registered colour/status outputs, one clock behind the sequencer state
  always_ff @(posedge clk) begin
    if (resetN) begin
      baseRGB        <= THEME_BASE[0];
      lineRGB        <= THEME_LINE[0];
      busy           <= 1'b0;
      transitionDone <= 1'b0;
    end else begin
      baseRGB        <= (state_q == FLASH) ? ~THEME_BASE[theme_q]
                                           : fade_rgb(THEME_BASE[theme_q], k_q);
      lineRGB        <= fade_rgb(THEME_LINE[theme_q], k_q);
      busy           <= (state_q != SHOW);
      transitionDone <= done_q;
    end
  end

endmodule
